// File: rtl/ovl_fire_collector.sv
// Collects fire vectors from a bank of OVL checkers: sticky flags, saturating event counters,
// first-failure capture with interrupt, optional halt-on-fire, and a four-phase clear handshake.
module ovl_fire_collector #(
   parameter int unsigned num_checkers = 4,
   parameter int unsigned idx_width    = 2,
   parameter int unsigned count_width  = 8,
   parameter bit          halt_on_fire = 1'b0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [3*num_checkers-1:0] fire_in,
   input  logic                      clr_req,
   input  logic [idx_width-1:0]      sel,
   output logic                      clr_ack,
   output logic                      irq,
   output logic                      tripped,
   output logic [idx_width-1:0]      first_idx,
   output logic [2:0]                first_type,
   output logic [2:0]                sel_sticky,
   output logic [count_width-1:0]    fail_count,
   output logic [count_width-1:0]    xcheck_count,
   output logic [count_width-1:0]    cover_count
);

   typedef enum logic [1:0] {StDisabled, StArmed, StTripped} state_e;

   state_e                           r_state;
   logic [num_checkers-1:0][2:0]     r_sticky;
   logic                             r_clr_ack;
   logic                             r_irq;
   logic                             r_tripped;
   logic [idx_width-1:0]             r_first_idx;
   logic [2:0]                       r_first_type;
   logic [count_width-1:0]           r_fail;
   logic [count_width-1:0]           r_xck;
   logic [count_width-1:0]           r_cov;

   logic                             w_any_fail;
   logic                             w_any_xck;
   logic                             w_any_cov;
   logic                             w_found;
   logic [idx_width-1:0]             w_lo_idx;
   logic [2:0]                       w_lo_type;
   logic [2:0]                       w_sel_sticky;

   // Reduce the fire vector; w_lo_* picks the lowest checker with an assertion or xcheck fire.
   always_comb begin
      w_any_fail = 1'b0;
      w_any_xck  = 1'b0;
      w_any_cov  = 1'b0;
      w_found    = 1'b0;
      w_lo_idx   = '0;
      w_lo_type  = '0;
      for (int i = 0; i < num_checkers; i++) begin
         w_any_fail = w_any_fail | fire_in[3*i];
         w_any_xck  = w_any_xck  | fire_in[3*i+1];
         w_any_cov  = w_any_cov  | fire_in[3*i+2];
         if (!w_found && (fire_in[3*i] || fire_in[3*i+1])) begin
            w_found   = 1'b1;
            w_lo_idx  = idx_width'(i);
            w_lo_type = fire_in[3*i +: 3];
         end
      end
   end

   always_comb begin
      w_sel_sticky = 3'b000;
      for (int i = 0; i < num_checkers; i++) begin
         if (sel == idx_width'(i)) w_sel_sticky = r_sticky[i];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= StDisabled;
         r_sticky     <= '0;
         r_clr_ack    <= 1'b0;
         r_irq        <= 1'b0;
         r_tripped    <= 1'b0;
         r_first_idx  <= '0;
         r_first_type <= '0;
         r_fail       <= '0;
         r_xck        <= '0;
         r_cov        <= '0;
      end else if (clr_req && !r_clr_ack) begin
         // Clear wins over any coincident fire; this cycle's fire_in is dropped.
         r_state      <= enable ? StArmed : StDisabled;
         r_sticky     <= '0;
         r_clr_ack    <= 1'b1;
         r_irq        <= 1'b0;
         r_tripped    <= 1'b0;
         r_first_idx  <= '0;
         r_first_type <= '0;
         r_fail       <= '0;
         r_xck        <= '0;
         r_cov        <= '0;
      end else begin
         if (r_clr_ack && !clr_req) r_clr_ack <= 1'b0;
         case (r_state)
            StDisabled: begin
               if (enable) r_state <= StArmed;
            end
            StArmed: begin
               r_sticky <= r_sticky | fire_in;
               if (w_any_fail && r_fail != '1) r_fail <= r_fail + count_width'(1);
               if (w_any_xck  && r_xck  != '1) r_xck  <= r_xck  + count_width'(1);
               if (w_any_cov  && r_cov  != '1) r_cov  <= r_cov  + count_width'(1);
               if (w_found && !r_irq) begin
                  r_irq        <= 1'b1;
                  r_first_idx  <= w_lo_idx;
                  r_first_type <= w_lo_type;
               end
               if (halt_on_fire && w_found) begin
                  r_state   <= StTripped;
                  r_tripped <= 1'b1;
               end else if (!enable) begin
                  r_state <= StDisabled;
               end
            end
            StTripped: begin
               r_state <= StTripped;
            end
            default: begin
               r_state <= StDisabled;
            end
         endcase
      end
   end

   assign clr_ack      = r_clr_ack;
   assign irq          = r_irq;
   assign tripped      = r_tripped;
   assign first_idx    = r_first_idx;
   assign first_type   = r_first_type;
   assign sel_sticky   = w_sel_sticky;
   assign fail_count   = r_fail;
   assign xcheck_count = r_xck;
   assign cover_count  = r_cov;

endmodule
